// File: rtl/input_port_nbank.sv
// Leaf-interface input port: N-bank reorder buffer indexed by sequence address,
// in-order drain into a FWFT output FIFO, and batched freespace credit packets.
module input_port_nbank #(
    parameter int unsigned PACKET_BITS           = 97,
    parameter int unsigned NUM_LEAF_BITS         = 6,
    parameter int unsigned NUM_PORT_BITS         = 4,
    parameter int unsigned NUM_ADDR_BITS         = 7,
    parameter int unsigned PAYLOAD_BITS          = 64,
    parameter int unsigned NUM_BANK_BITS         = 1,
    parameter int unsigned PORT_No               = 2,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
    parameter int unsigned OUT_FIFO_ASIZE        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
    input  logic [NUM_LEAF_BITS-1:0] src_leaf,
    input  logic [NUM_PORT_BITS-1:0] src_port,
    input  logic                     ap_start,
    output logic                     freespace_update,
    output logic [PACKET_BITS-1:0]   packet_from_input_port,
    output logic [PAYLOAD_BITS-1:0]  dout2user,
    output logic                     vld2user,
    input  logic                     ack_user2b_in,
    output logic                     overflow_err
);
    localparam int unsigned NUM_BANKS  = 1 << NUM_BANK_BITS;
    localparam int unsigned ROW_BITS   = NUM_ADDR_BITS - NUM_BANK_BITS;
    localparam int unsigned NUM_ROWS   = 1 << ROW_BITS;
    localparam int unsigned FIFO_DEPTH = 1 << OUT_FIFO_ASIZE;
    localparam int unsigned PAD_BITS   = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;
    localparam int unsigned CR_BITS    = NUM_ADDR_BITS + 1;

    logic                     w_valid;
    logic [NUM_PORT_BITS-1:0] w_port;
    logic [NUM_ADDR_BITS-1:0] w_addr;
    logic [PAYLOAD_BITS-1:0]  w_payload;
    logic                     w_unused_din;

    assign w_valid      = din_leaf_bft2interface[PACKET_BITS-1];
    assign w_port       = din_leaf_bft2interface[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
    assign w_addr       = din_leaf_bft2interface[PAYLOAD_BITS+NUM_ADDR_BITS-1:PAYLOAD_BITS];
    assign w_payload    = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
    assign w_unused_din = ^{din_leaf_bft2interface[PACKET_BITS-2 -: NUM_LEAF_BITS],
                            din_leaf_bft2interface[PACKET_BITS-2-NUM_LEAF_BITS-NUM_PORT_BITS :
                                                   PAYLOAD_BITS+NUM_ADDR_BITS]};

    logic [NUM_ADDR_BITS-1:0] r_rd_ptr;
    logic [NUM_ROWS*NUM_BANKS-1:0] r_occ;
    logic                     r_inflight;
    logic [NUM_BANK_BITS-1:0] r_sel_bank;
    logic [OUT_FIFO_ASIZE:0]  r_count;
    logic [CR_BITS-1:0]       r_cr_cnt;
    logic                     r_fsu;
    logic                     r_ovf;

    logic                     w_wr_req;
    logic                     w_wr_ok;
    logic                     w_bypass;
    logic                     w_room;
    logic                     w_issue;
    logic [NUM_BANK_BITS-1:0] w_wr_bank;
    logic [ROW_BITS-1:0]      w_wr_row;
    logic [NUM_BANK_BITS-1:0] w_rd_bank;
    logic [ROW_BITS-1:0]      w_rd_row;

    assign w_wr_req  = w_valid && (w_port == NUM_PORT_BITS'(PORT_No)) && ap_start;
    assign w_wr_ok   = w_wr_req && !r_occ[w_addr];
    assign w_wr_bank = w_addr[NUM_BANK_BITS-1:0];
    assign w_wr_row  = w_addr[NUM_ADDR_BITS-1:NUM_BANK_BITS];
    assign w_rd_bank = r_rd_ptr[NUM_BANK_BITS-1:0];
    assign w_rd_row  = r_rd_ptr[NUM_ADDR_BITS-1:NUM_BANK_BITS];

    // A write to the next-expected address is issued in the same cycle, reading the payload
    // straight off the input; this gives the two-cycle write-to-valid latency.
    assign w_bypass = w_wr_ok && (w_addr == r_rd_ptr);
    assign w_room   = (r_count + {{OUT_FIFO_ASIZE{1'b0}}, r_inflight}) < (OUT_FIFO_ASIZE+1)'(FIFO_DEPTH);
    assign w_issue  = ap_start && (r_occ[r_rd_ptr] || w_bypass) && w_room;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ      <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_sel_bank <= '0;
            r_ovf      <= 1'b0;
        end else begin
            // Clear is ordered after set so a bypassed write never leaves its slot occupied.
            if (w_wr_ok) r_occ[w_addr] <= 1'b1;
            if (w_issue) begin
                r_occ[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
                r_sel_bank      <= w_rd_bank;
            end
            r_inflight <= w_issue;
            if (w_wr_req && r_occ[w_addr]) r_ovf <= 1'b1;
        end
    end

    logic [PAYLOAD_BITS-1:0] w_bank_q [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [PAYLOAD_BITS-1:0] r_mem [NUM_ROWS];
        logic [PAYLOAD_BITS-1:0] r_q;
        always_ff @(posedge clk) begin
            if (w_wr_ok && (w_wr_bank == NUM_BANK_BITS'(b))) r_mem[w_wr_row] <= w_payload;
            if (w_issue && (w_rd_bank == NUM_BANK_BITS'(b)))
                r_q <= w_bypass ? w_payload : r_mem[w_rd_row];
        end
        assign w_bank_q[b] = r_q;
    end

    logic [PAYLOAD_BITS-1:0]   r_fifo [FIFO_DEPTH];
    logic [OUT_FIFO_ASIZE-1:0] r_wptr;
    logic [OUT_FIFO_ASIZE-1:0] r_rptr;
    logic                      w_push;
    logic                      w_pop;

    assign w_push    = r_inflight;
    assign vld2user  = (r_count != '0);
    assign w_pop     = vld2user && ack_user2b_in;
    assign dout2user = vld2user ? r_fifo[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= w_bank_q[r_sel_bank];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cr_cnt <= '0;
            r_fsu    <= 1'b0;
        end else begin
            r_fsu <= 1'b0;
            if (w_issue) begin
                if (r_cr_cnt + 1'b1 == CR_BITS'(FREESPACE_UPDATE_SIZE)) begin
                    r_cr_cnt <= '0;
                    r_fsu    <= 1'b1;
                end else begin
                    r_cr_cnt <= r_cr_cnt + 1'b1;
                end
            end
        end
    end

    assign freespace_update       = r_fsu;
    assign overflow_err           = r_ovf;
    assign packet_from_input_port = r_fsu ? {1'b1, src_leaf, src_port, {PAD_BITS{1'b0}},
                                             PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)} : '0;
endmodule
